obi_arb2: RTL and testbench
===========================

Name: obi_arb2

Overview:
- Two-requester arbiter sharing one OBI slave peripheral port (e.g. gpio_top) between a primary master (core LSU, m0) and a secondary master (debug/DMA, m1).
- Performs round-robin request arbitration and muxes the request onto the slave.
- Tracks granted-but-unanswered transactions in an ID FIFO and routes each slave rvalid/rdata back to the master that issued it.
- Sits between the bus interconnect and a single peripheral instance.

Parameters:
- MAX_OUTST, 2, max accepted-but-unanswered transactions (ID FIFO depth, power of two, >=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  master request
- m0_we_i / m1_we_i  in  1  write enable
- m0_be_i / m1_be_i  in  4  byte enables
- m0_addr_i / m1_addr_i  in  32  address
- m0_data_i / m1_data_i  in  32  write data
- m0_gnt_o / m1_gnt_o  out  1  grant
- m0_rvalid_o / m1_rvalid_o  out  1  response valid
- m0_data_o / m1_data_o  out  32  read data
- s_req_o  out  1  slave request
- s_we_o  out  1  write enable
- s_be_o  out  4  byte enables
- s_addr_o  out  32  address
- s_data_o  out  32  write data
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_data_i  in  32  slave read data
- err_o  out  1  sticky: slave rvalid arrived with no outstanding transaction

Behaviour:
- Reset (async, rst_ni low):
  - FIFO empty, count=0.
  - Priority pointer = m0.
  - err_o=0.
- Output values during reset:
  - All gnt/rvalid outputs and s_req_o are 0.
  - Data outputs are 0 because no request is selected and the FIFO is empty.
- can_issue = (count < MAX_OUTST) | s_rvalid_i. A pop in the same cycle frees a slot.
- Selection (combinational):
  - If only one master requests, select it.
  - If both request, select the master the pointer favours.
  - If neither requests, select none.
- Slave request muxing:
  - s_req_o = selected master's req & can_issue.
  - s_we/be/addr/data_o = selected master's fields; all zeros when none is selected.
- Master grant: mX_gnt_o = (X selected) & can_issue & s_gnt_i. The path is combinational and adds zero cycles of latency.
- On a handshake (s_req_o & s_gnt_i):
  - Push the master ID (0/1) into the FIFO.
  - Pointer moves to favour the other master on the next cycle.
  - With no handshake, the pointer holds.
- On s_rvalid_i with count>0:
  - Pop the head ID.
  - Assert rvalid_o of that master only, same cycle (combinational). The other master's rvalid_o stays 0.
  - The selected master's data_o = s_data_i. The non-selected master's data_o = 0.
- On s_rvalid_i with count==0:
  - No master rvalid.
  - err_o set to 1; it stays set until reset.
  - FIFO unchanged.
- Push and pop in the same cycle: count unchanged, ordering preserved (pop old head, write new tail).
- FIFO full with no pop: no handshake is offered (s_req_o=0), both gnt_o=0, and requests wait.
- Pointers wrap modulo MAX_OUTST; count is clog2(MAX_OUTST)+1 bits wide.
- Masters must hold req/fields stable until gnt. The arbiter may re-select on any ungranted cycle, and the round-robin pointer only moves on a handshake.
- With gpio_top (gnt=req, rvalid 1 cycle later), m0-only traffic achieves 1 transaction/cycle with MAX_OUTST>=1.
- Reset mid-operation drops all outstanding IDs. Responses arriving after reset are treated as spurious and set err_o.

Test Plan:
- Reset, idle -> all outputs 0, err_o=0.
- m0 read of addr 0x0000_0004, slave gnt=req and rvalid next cycle with data 0xA5A5_0001:
  - m0_gnt_o=1 in cycle 0.
  - m0_rvalid_o=1 with m0_data_o=0xA5A5_0001 in cycle 1.
  - m1_rvalid_o=0.
- m0 and m1 request continuously for 4 cycles from reset -> grant order m0,m1,m0,m1; each rvalid is routed to the issuing master one cycle after its grant.
- MAX_OUTST=2, slave holds rvalid low for 3 cycles after 2 grants:
  - Third request sees s_req_o=0 and gnt=0.
  - In the first cycle s_rvalid_i=1, the third request is granted alongside the pop, and count stays 2.
- s_rvalid_i pulse with the FIFO empty -> no master rvalid, err_o=1, which persists until rst_ni goes low.
- rst_ni asserted with 2 outstanding, then deasserted, then one s_rvalid_i -> FIFO empty, err_o=1, and neither master sees rvalid.

Source files
------------

// File: rtl/obi_arb2.sv
// Two-master round-robin arbiter in front of a single OBI slave port.
// Issuing master IDs are queued in order so each slave response returns to its requester.
module obi_arb2 #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_data_i,

    output logic        err_o
);

    // Handshakes: a request transfers in the cycle where req and gnt are both high;
    // the master must hold req and all fields stable until that cycle. A response
    // transfers in every cycle rvalid is high; there is no response back-pressure.

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

    logic [MAX_OUTST-1:0] id_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 prio_q;
    logic                 err_q;

    logic                 fifo_empty;
    logic                 can_issue;
    logic                 sel_valid;
    logic                 sel_id;
    logic                 push;
    logic                 pop;
    logic                 head_id;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count_q == '0);
    // A response popping this cycle frees a slot for a new grant in the same cycle.
    assign can_issue  = (count_q < CNT_MAX) | s_rvalid_i;

    always_comb begin
        sel_valid = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) begin
            sel_id = prio_q;
        end else begin
            sel_id = m1_req_i;
        end
    end

    always_comb begin
        s_we_o   = 1'b0;
        s_be_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (sel_valid) begin
            if (sel_id) begin
                s_we_o   = m1_we_i;
                s_be_o   = m1_be_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
            end else begin
                s_we_o   = m0_we_i;
                s_be_o   = m0_be_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
            end
        end
    end

    assign s_req_o  = sel_valid & can_issue;
    assign m0_gnt_o = sel_valid & ~sel_id & can_issue & s_gnt_i;
    assign m1_gnt_o = sel_valid &  sel_id & can_issue & s_gnt_i;
    assign push     = s_req_o & s_gnt_i;

    assign pop     = s_rvalid_i & ~fifo_empty;
    assign head_id = id_q[rd_ptr_q];

    assign m0_rvalid_o = pop & ~head_id;
    assign m1_rvalid_o = pop &  head_id;
    assign m0_data_o   = m0_rvalid_o ? s_data_i : '0;
    assign m1_data_o   = m1_rvalid_o ? s_data_i : '0;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr_q] <= sel_id;
                wr_ptr_q       <= next_ptr(wr_ptr_q);
                prio_q         <= ~sel_id;
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A response with nothing outstanding means the slave and arbiter disagree.
            if (s_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_arb2.sv
// Directed bench for obi_arb2: reset, single read, round-robin order,
// full-FIFO stall, spurious responses and reset with transactions in flight.
module tb_obi_arb2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, err_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        slave_gnt_en;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    // Slave grants whatever it is offered while enabled, like gpio_top.
    assign s_gnt_i = s_req_o & slave_gnt_en;

    obi_arb2 #(.MAX_OUTST(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_data_i(s_data_i),
        .err_o(err_o)
    );

    task automatic idle_inputs;
        m0_req_i = 0; m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_data_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_data_i = '0;
        s_rvalid_i = 0; s_data_i = '0; slave_gnt_en = 1;
    endtask

    // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_ni = 0;
        next_cycle();
        next_cycle();
        rst_ni = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_ni = 0;
        #2;
        @(negedge clk_i);
        total++; if (s_req_o !== 1'b0) begin bad++; $display("FAIL rst_s_req got=%b exp=0", s_req_o); end
        total++; if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0)
            begin bad++; $display("FAIL rst_gnt_rvalid got=%b exp=0000", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}); end
        total++; if ({s_we_o, s_be_o, s_addr_o, s_data_o} !== 69'b0)
            begin bad++; $display("FAIL rst_s_fields got=%h exp=0", {s_we_o, s_be_o, s_addr_o, s_data_o}); end
        total++; if ({m0_data_o, m1_data_o} !== 64'b0)
            begin bad++; $display("FAIL rst_m_data got=%h exp=0", {m0_data_o, m1_data_o}); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
        next_cycle();
        rst_ni = 1;
        next_cycle();
    endtask

    task automatic test_single_read;
        do_reset();
        // Cycle 0: m0 read of 0x4, granted immediately.
        m0_req_i = 1; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h0000_0004;
        @(negedge clk_i);
        total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL rd_m0_gnt got=%b exp=1", m0_gnt_o); end
        total++; if (s_addr_o !== 32'h4) begin bad++; $display("FAIL rd_s_addr got=%h exp=00000004", s_addr_o); end
        total++; if (s_be_o !== 4'hF) begin bad++; $display("FAIL rd_s_be got=%h exp=f", s_be_o); end
        total++; if (m0_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_early_rvalid got=%b exp=0", m0_rvalid_o); end
        next_cycle();
        // Cycle 1: response.
        m0_req_i = 0; m0_addr_i = '0; m0_be_i = '0;
        s_rvalid_i = 1; s_data_i = 32'hA5A5_0001;
        @(negedge clk_i);
        total++; if (m0_rvalid_o !== 1'b1) begin bad++; $display("FAIL rd_m0_rvalid got=%b exp=1", m0_rvalid_o); end
        total++; if (m0_data_o !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_m0_data got=%h exp=a5a50001", m0_data_o); end
        total++; if (m1_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_m1_rvalid got=%b exp=0", m1_rvalid_o); end
        total++; if (m1_data_o !== 32'h0) begin bad++; $display("FAIL rd_m1_data got=%h exp=0", m1_data_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", err_o); end
        next_cycle();
    endtask

    task automatic test_round_robin;
        logic        e_g0, e_g1, e_r0, e_r1;
        logic [31:0] e_addr, e_data;
        do_reset();
        m0_addr_i = 32'h0000_0100;
        m1_addr_i = 32'h0000_0200;
        for (int k = 0; k < 5; k++) begin
            m0_req_i   = (k < 4);
            m1_req_i   = (k < 4);
            s_rvalid_i = (k >= 1);
            s_data_i   = 32'hD000_0000 + k;
            e_g0   = (k < 4) && (k % 2 == 0);
            e_g1   = (k < 4) && (k % 2 == 1);
            e_r0   = (k >= 1) && ((k - 1) % 2 == 0);
            e_r1   = (k >= 1) && ((k - 1) % 2 == 1);
            e_addr = (k >= 4) ? 32'h0 : ((k % 2 == 0) ? 32'h100 : 32'h200);
            e_data = 32'hD000_0000 + k;
            @(negedge clk_i);
            total++; if ({m0_gnt_o, m1_gnt_o} !== {e_g0, e_g1})
                begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b%b exp=%b%b", k, m0_gnt_o, m1_gnt_o, e_g0, e_g1); end
            total++; if (s_addr_o !== e_addr)
                begin bad++; $display("FAIL rr_addr cyc=%0d got=%h exp=%h", k, s_addr_o, e_addr); end
            total++; if ({m0_rvalid_o, m1_rvalid_o} !== {e_r0, e_r1})
                begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b%b", k, m0_rvalid_o, m1_rvalid_o, e_r0, e_r1); end
            total++; if ((e_r0 ? m0_data_o : m1_data_o) !== ((e_r0 || e_r1) ? e_data : 32'h0))
                begin bad++; $display("FAIL rr_data cyc=%0d got=%h/%h exp=%h", k, m0_data_o, m1_data_o, e_data); end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rr_err got=%b exp=0", err_o); end
        next_cycle();
    endtask

    task automatic test_full_stall;
        do_reset();
        // Two grants without responses fill the FIFO: m0 then m1.
        m0_req_i = 1; m0_addr_i = 32'h10;
        @(negedge clk_i);
        total++; if (m0_gnt_o !== 1'b1) begin bad++; $display("FAIL full_g0 got=%b exp=1", m0_gnt_o); end
        next_cycle();
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h20;
        @(negedge clk_i);
        total++; if (m1_gnt_o !== 1'b1) begin bad++; $display("FAIL full_g1 got=%b exp=1", m1_gnt_o); end
        next_cycle();
        m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            total++; if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b000)
                begin bad++; $display("FAIL full_stall cyc=%0d got=%b exp=000", k, {s_req_o, m0_gnt_o, m1_gnt_o}); end
            next_cycle();
        end
        // First response frees a slot: third request granted in the same cycle.
        s_rvalid_i = 1; s_data_i = 32'h1111_0001;
        @(negedge clk_i);
        total++; if ({s_req_o, m0_gnt_o} !== 2'b11) begin bad++; $display("FAIL full_pop_gnt got=%b exp=11", {s_req_o, m0_gnt_o}); end
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10 || m0_data_o !== 32'h1111_0001)
            begin bad++; $display("FAIL full_pop_rv got=%b%b/%h exp=10/11110001", m0_rvalid_o, m1_rvalid_o, m0_data_o); end
        next_cycle();
        // Count stayed at 2: m1's and then the third (m0) response remain, in order.
        m0_req_i = 0; s_data_i = 32'h2222_0002;
        @(negedge clk_i);
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01 || m1_data_o !== 32'h2222_0002)
            begin bad++; $display("FAIL full_second_rv got=%b%b/%h exp=01/22220002", m0_rvalid_o, m1_rvalid_o, m1_data_o); end
        next_cycle();
        s_data_i = 32'h3333_0003;
        @(negedge clk_i);
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10 || m0_data_o !== 32'h3333_0003)
            begin bad++; $display("FAIL full_third_rv got=%b%b/%h exp=10/33330003", m0_rvalid_o, m1_rvalid_o, m0_data_o); end
        next_cycle();
        s_rvalid_i = 0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", err_o); end
        next_cycle();
    endtask

    task automatic test_spurious;
        do_reset();
        s_rvalid_i = 1; s_data_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00)
            begin bad++; $display("FAIL sp_rvalid got=%b%b exp=00", m0_rvalid_o, m1_rvalid_o); end
        total++; if ({m0_data_o, m1_data_o} !== 64'h0)
            begin bad++; $display("FAIL sp_data got=%h exp=0", {m0_data_o, m1_data_o}); end
        next_cycle();
        s_rvalid_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            total++; if (err_o !== 1'b1) begin bad++; $display("FAIL sp_err_sticky cyc=%0d got=%b exp=1", k, err_o); end
            next_cycle();
        end
        rst_ni = 0;
        #1;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL sp_err_clear got=%b exp=0", err_o); end
        next_cycle();
        rst_ni = 1;
        next_cycle();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h40;
        next_cycle();
        m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h50;
        next_cycle();
        m1_req_i = 0;
        rst_ni = 0;
        next_cycle();
        rst_ni = 1;
        // FIFO empty after reset: a request is offered even without a response.
        slave_gnt_en = 0; m0_req_i = 1;
        @(negedge clk_i);
        total++; if (s_req_o !== 1'b1) begin bad++; $display("FAIL mid_empty_req got=%b exp=1", s_req_o); end
        next_cycle();
        m0_req_i = 0; slave_gnt_en = 1;
        s_rvalid_i = 1; s_data_i = 32'h5555_AAAA;
        @(negedge clk_i);
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00)
            begin bad++; $display("FAIL mid_rvalid got=%b%b exp=00", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        s_rvalid_i = 0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL mid_err got=%b exp=1", err_o); end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_stall();
        test_spurious();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
